mem_stage: RTL and testbench

Memory-access stage of the 5-stage RISC-V pipeline. It consumes the EX/MEM pipeline register outputs and resolves branches. It drives loads and stores to the data memory over a req/ack handshake, freezing the upstream pipeline while an access is outstanding. Results are registered into the MEM/WB register fields for the write-back stage.

---
 rtl/mem_stage.sv | 109 ++++++++++
 tb/tb_mem_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: resolves branches, runs data-memory loads/stores over a req/ack
// handshake with a bounded wait, and registers results into the MEM/WB fields.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] addsum_in,
  input  logic [63:0] alures_in,
  input  logic        zero_in,
  input  logic [63:0] rd2_in,
  input  logic [4:0]  rd_in,
  input  logic        regwrite_in,
  input  logic        memtoreg_in,
  input  logic        branch_in,
  input  logic        memread_in,
  input  logic        memwrite_in,
  output logic        pcsrc,
  output logic [63:0] branch_target,
  output logic        stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [63:0] dm_addr,
  output logic [63:0] dm_wdata,
  input  logic [63:0] dm_rdata,
  input  logic        dm_ack,
  output logic [63:0] wb_readdata,
  output logic [63:0] wb_alures,
  output logic [4:0]  wb_rd,
  output logic        wb_regwrite,
  output logic        wb_memtoreg,
  output logic        mem_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {StIdle, StAccess} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          memop;
  logic          timeout_hit;

  assign memop         = memread_in | memwrite_in;
  assign timeout_hit   = (state == StAccess) && !dm_ack && (count == CW'(TIMEOUT - 1));
  // Upstream is released on the ack or timeout cycle so the next instruction can enter.
  assign stall         = (state == StIdle) ? memop : (!dm_ack && !timeout_hit);
  assign pcsrc         = branch_in & zero_in & (state == StIdle) & ~memop;
  assign branch_target = addsum_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      count       <= '0;
      dm_req      <= 1'b0;
      dm_we       <= 1'b0;
      dm_addr     <= '0;
      dm_wdata    <= '0;
      wb_readdata <= '0;
      wb_alures   <= '0;
      wb_rd       <= '0;
      wb_regwrite <= 1'b0;
      wb_memtoreg <= 1'b0;
      mem_err     <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (memop) begin
            dm_req      <= 1'b1;
            dm_we       <= memwrite_in;
            dm_addr     <= alures_in;
            dm_wdata    <= rd2_in;
            count       <= '0;
            wb_regwrite <= 1'b0;
            state       <= StAccess;
          end else begin
            wb_readdata <= '0;
            wb_alures   <= alures_in;
            wb_rd       <= rd_in;
            wb_regwrite <= regwrite_in;
            wb_memtoreg <= memtoreg_in;
          end
        end
        StAccess: begin
          if (dm_ack) begin
            // dm_we already encodes store precedence when both read and write are set.
            wb_readdata <= dm_we ? 64'd0 : dm_rdata;
            wb_alures   <= alures_in;
            wb_rd       <= rd_in;
            wb_regwrite <= regwrite_in;
            wb_memtoreg <= memtoreg_in;
            dm_req      <= 1'b0;
            state       <= StIdle;
          end else if (timeout_hit) begin
            dm_req      <= 1'b0;
            mem_err     <= 1'b1;
            wb_regwrite <= 1'b0;
            state       <= StIdle;
          end else begin
            count       <= count + CW'(1);
            wb_regwrite <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed instructions feed a scoreboard queue that a separate
// monitor drains whenever the stage retires an instruction.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic [63:0] addsum_in, alures_in, rd2_in, dm_rdata;
  logic        zero_in, regwrite_in, memtoreg_in, branch_in, memread_in, memwrite_in;
  logic [4:0]  rd_in;
  logic        dm_ack;
  logic        pcsrc, stall, dm_req, dm_we;
  logic [63:0] branch_target, dm_addr, dm_wdata, wb_readdata, wb_alures;
  logic [4:0]  wb_rd;
  logic        wb_regwrite, wb_memtoreg, mem_err;

  typedef struct {
    logic [63:0] rdata;
    logic [63:0] alures;
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
    logic        err;
    logic        full;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic drv_valid = 1'b0;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .addsum_in    (addsum_in),
    .alures_in    (alures_in),
    .zero_in      (zero_in),
    .rd2_in       (rd2_in),
    .rd_in        (rd_in),
    .regwrite_in  (regwrite_in),
    .memtoreg_in  (memtoreg_in),
    .branch_in    (branch_in),
    .memread_in   (memread_in),
    .memwrite_in  (memwrite_in),
    .pcsrc        (pcsrc),
    .branch_target(branch_target),
    .stall        (stall),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_rdata     (dm_rdata),
    .dm_ack       (dm_ack),
    .wb_readdata  (wb_readdata),
    .wb_alures    (wb_alures),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .wb_memtoreg  (wb_memtoreg),
    .mem_err      (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    addsum_in = '0; alures_in = '0; rd2_in = '0; rd_in = '0; zero_in = 0;
    regwrite_in = 0; memtoreg_in = 0; branch_in = 0; memread_in = 0; memwrite_in = 0;
    dm_ack = 0; dm_rdata = '0;
  endtask

  // Monitor: an instruction retires on any non-reset edge where stall was low.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (drv_valid && !stall && !reset) begin
        #1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow actual=retire required=none");
        end else begin
          e = exp_q.pop_front();
          if (e.full) begin
            check("wb_readdata", wb_readdata, e.rdata);
            check("wb_alures", wb_alures, e.alures);
            check("wb_rd", 64'(wb_rd), 64'(e.rd));
            check("wb_memtoreg", 64'(wb_memtoreg), 64'(e.m2r));
          end
          check("wb_regwrite", 64'(wb_regwrite), 64'(e.rw));
          check("mem_err", 64'(mem_err), 64'(e.err));
        end
      end
    end
  end

  // ack_at: ACCESS cycle (1-based) on which dm_ack pulses; 0 or negative means never.
  task automatic issue(input logic [63:0] alu, input logic [63:0] addsum, input logic [63:0] rd2,
                       input logic [4:0] rd, input logic zero, input logic rw, input logic m2r,
                       input logic br, input logic mr, input logic mw, input int ack_at,
                       input logic [63:0] rdata, input logic exp_pcsrc, input int exp_occ,
                       input int exp_req, input exp_t e);
    int  occ = 0;
    int  reqs = 0;
    int  acc = 0;
    bit  done = 0;
    @(negedge clk);
    alures_in = alu; addsum_in = addsum; rd2_in = rd2; rd_in = rd; zero_in = zero;
    regwrite_in = rw; memtoreg_in = m2r; branch_in = br; memread_in = mr; memwrite_in = mw;
    drv_valid = 1'b1;
    exp_q.push_back(e);
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) @(negedge clk);
      if (dm_req) begin
        acc++;
        reqs++;
        dm_ack   = (acc == ack_at);
        dm_rdata = dm_ack ? rdata : 64'h5555_5555_5555_5555;
        check("dm_addr", dm_addr, alu);
        check("dm_we", 64'(dm_we), 64'(mw));
        check("dm_wdata", dm_wdata, rd2);
      end else begin
        dm_ack = 1'b0;
      end
      #1;
      if (c == 0) begin
        check("pcsrc", 64'(pcsrc), 64'(exp_pcsrc));
        check("branch_target", branch_target, addsum);
      end
      occ++;
      if (!stall) done = 1;
      @(posedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL retire_bound actual=stalled required=retire");
    end
    @(negedge clk);
    drv_valid = 1'b0;
    clear_inputs();
    check("occupancy", 64'(occ), 64'(exp_occ));
    check("req_cycles", 64'(reqs), 64'(exp_req));
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dm_req", 64'(dm_req), 64'd0);
    check("rst_dm_we", 64'(dm_we), 64'd0);
    check("rst_dm_addr", dm_addr, 64'd0);
    check("rst_dm_wdata", dm_wdata, 64'd0);
    check("rst_wb_alures", wb_alures, 64'd0);
    check("rst_wb_regwrite", 64'(wb_regwrite), 64'd0);
    check("rst_mem_err", 64'(mem_err), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    reset = 1'b0;

    // ALU op
    issue(64'h40, 64'h0, 64'h0, 5'd5, 0, 1, 0, 0, 0, 0, 0, 64'h0, 0, 1, 0,
          '{64'h0, 64'h40, 5'd5, 1, 0, 0, 1});
    // Load, ack on 3rd ACCESS cycle; branch bits set but memop blocks pcsrc
    issue(64'h100, 64'h900, 64'h0, 5'd7, 1, 1, 1, 1, 1, 0, 3, 64'hDEADBEEF, 0, 4, 3,
          '{64'hDEADBEEF, 64'h100, 5'd7, 1, 1, 0, 1});
    // Store, immediate ack
    issue(64'h80, 64'h0, 64'h1234, 5'd0, 0, 0, 0, 0, 0, 1, 1, 64'hBAD, 0, 2, 1,
          '{64'h0, 64'h80, 5'd0, 0, 0, 0, 1});
    // Load with ack on the last allowed cycle: ack beats timeout
    issue(64'h300, 64'h0, 64'h0, 5'd9, 0, 1, 1, 0, 1, 0, 4, 64'hCAFE, 0, 5, 4,
          '{64'hCAFE, 64'h300, 5'd9, 1, 1, 0, 1});
    // Branch taken / not taken
    issue(64'h11, 64'h200, 64'h0, 5'd0, 1, 0, 0, 1, 0, 0, 0, 64'h0, 1, 1, 0,
          '{64'h0, 64'h11, 5'd0, 0, 0, 0, 1});
    issue(64'h22, 64'h200, 64'h0, 5'd0, 0, 0, 0, 1, 0, 0, 0, 64'h0, 0, 1, 0,
          '{64'h0, 64'h22, 5'd0, 0, 0, 0, 1});
    // Load with no ack: times out after 4 ACCESS cycles, dropped, error raised
    issue(64'h400, 64'h0, 64'h0, 5'd3, 0, 1, 1, 0, 1, 0, -1, 64'h0, 0, 5, 4,
          '{64'h0, 64'h0, 5'd0, 0, 0, 1, 0});
    // Error is sticky across later instructions
    issue(64'h55, 64'h0, 64'h0, 5'd1, 0, 1, 0, 0, 0, 0, 0, 64'h0, 0, 1, 0,
          '{64'h0, 64'h55, 5'd1, 1, 0, 1, 1});

    // Reset during the 2nd ACCESS cycle aborts the access and clears the error
    @(negedge clk);
    alures_in = 64'h500; rd_in = 5'd4; regwrite_in = 1; memtoreg_in = 1; memread_in = 1;
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_req", 64'(dm_req), 64'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("arst_dm_req", 64'(dm_req), 64'd0);
    check("arst_wb_alures", wb_alures, 64'd0);
    check("arst_wb_readdata", wb_readdata, 64'd0);
    check("arst_wb_rd", 64'(wb_rd), 64'd0);
    check("arst_wb_regwrite", 64'(wb_regwrite), 64'd0);
    check("arst_wb_memtoreg", 64'(wb_memtoreg), 64'd0);
    check("arst_mem_err", 64'(mem_err), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    #1;
    check("arst_stall", 64'(stall), 64'd0);

    repeat (3) @(posedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
